uart_mult_ctrl: RTL and testbench
=================================

# uart_mult_ctrl

Command controller between the `uart_rx_tx` byte link and the transmit path: it collects two received operand bytes, multiplies them with an 8-cycle shift-add datapath, and returns the 16-bit product as two bytes, MSB first, through the UART transmitter. It connects directly to `uart_rx_valid`/`uart_received_data` and drives `uart_tx_start`/`uart_transmit_data`, observing `uart_tx_ready`.

## Interface

Parameters:
- `RX_TIMEOUT`, default 100000: clock cycles allowed between operand A and operand B before A is discarded. 10 ms at 10 MHz. Legal range 2 to 2^24−1.

Ports:
- `clk_int` in 1: single system clock.
- `uart_reset` in 1: reset. Asynchronous, active-low.
- `uart_received_data` in 8: byte from the UART receiver.
- `uart_rx_valid` in 1: receive strobe. A byte is captured on the cycle a rising edge of this signal is detected.
- `uart_tx_ready` in 1: transmitter idle (1) or busy (0).
- `uart_transmit_data` out 8: byte presented to the transmitter.
- `uart_tx_start` out 1: transmit request.
- `result` out 16: last product. Holds until the next product.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `busy` out 1: high in MULT and all TX states.
- `rx_timeout` out 1: one-cycle pulse when a pending operand A is discarded.
- `rx_overrun` out 1: one-cycle pulse when a byte arrives while `busy` and is dropped.

## Operation

- Reset: all outputs 0, state IDLE. The internal `uart_rx_valid` edge-detect register resets to 0.
- Byte event: `uart_rx_valid == 1` while the registered previous value is 0. A level held high produces one event only.
- States:
  - IDLE: on a byte event, store it in A, clear the timeout counter, go to WAIT_B.
  - WAIT_B: on a byte event, store it in B and go to MULT. Otherwise, when the counter reaches `RX_TIMEOUT−1`, pulse `rx_timeout` and go to IDLE. If a byte event and the timeout occur in the same cycle, the byte wins: no timeout is raised.
  - MULT: 8 iterations, one per cycle. Each cycle, if the current multiplier LSB is 1, add the shifted multiplicand into a 16-bit accumulator. Arithmetic is unsigned with no overflow, since 255×255 = 0xFE01. After the 8th cycle, load `result`, pulse `result_valid`, go to TX_HI_REQ.
  - TX_HI_REQ: `uart_transmit_data = result[15:8]`, `uart_tx_start = 1`. Hold both until `uart_tx_ready == 0` is sampled, then go to TX_HI_WAIT.
  - TX_HI_WAIT: `uart_tx_start = 0`. On `uart_tx_ready == 1`, go to TX_LO_REQ.
  - TX_LO_REQ and TX_LO_WAIT: same as the HI pair, using `result[7:0]`. Exit to IDLE.
- Byte events in MULT or TX states: the byte is dropped, `rx_overrun` pulses, and state and result are unaffected.
- `uart_transmit_data` is registered. It holds its last value outside the REQ states.

## Timing

- B byte event at cycle N: MULT occupies N+1..N+8. `result`/`result_valid` and `uart_tx_start` rise at N+9.
- Start handshake: `uart_tx_start` deasserts on the cycle after `uart_tx_ready` is sampled low. It never re-asserts before `uart_tx_ready` has returned high.
- If `uart_tx_ready` is already 0 on entry to a REQ state, the block advances to WAIT on the next cycle. The transmitter is then responsible for having latched the byte.
- Timeout: the counter increments every cycle in WAIT_B. `rx_timeout` pulses exactly `RX_TIMEOUT` cycles after the A event when no B arrives.
- Reset asserted mid-operation, in any state: outputs go to 0 asynchronously and state returns to IDLE. A partially sent result is not resumed.
- `busy` is a registered decode of the state. It rises the cycle after the B event and falls on entry to IDLE.

## Test plan

- Bytes 0x02 then 0x0A, with the transmitter modeled or real at `freq_control = 00` -> `result = 0x0014`, `result_valid` one pulse, transmitted bytes 0x00 then 0x14, `rx_overrun` and `rx_timeout` never pulse.
- Bytes 0xFF, 0xFF -> `result = 0xFE01`, transmitted bytes 0xFE then 0x01. Bytes 0x00, 0x5A -> `result = 0x0000`, two 0x00 bytes sent.
- Send 0x07, then no byte for `RX_TIMEOUT` cycles (bench uses `RX_TIMEOUT = 50`) -> `rx_timeout` pulses once at cycle 50. Then 0x03, 0x04 -> `result = 0x000C`.
- Send 0x10, 0x10, then a third byte 0x55 during MULT or TX -> `rx_overrun` pulses, the transmitted bytes are 0x01, 0x00, and the block is idle afterwards with no pending A.
- Hold `uart_rx_valid` high for 5 cycles carrying 0x03, then pulse 0x05 -> exactly one product, 0x000F.
- Assert `uart_reset` low while in TX_HI_REQ -> `uart_tx_start` goes to 0 immediately and all outputs are 0. After release, 0x02, 0x03 -> `result = 0x0006` and normal transmission.

Source files
------------

// File: rtl/uart_mult_ctrl.sv
// uart_mult_ctrl: collects two operand bytes from the UART receiver, multiplies them
//   with an 8-cycle shift-add datapath and returns the 16-bit product MSB first.
// Latency: B byte event to result/result_valid/uart_tx_start is 9 cycles.
// Backpressure: each byte is held on uart_tx_start until uart_tx_ready is seen low, then
//   the block waits for ready high. Bytes arriving while busy are dropped (rx_overrun).
//
// Ports:
//   clk_int            system clock
//   uart_reset         asynchronous active-low reset
//   uart_received_data byte from the receiver, taken on a rising edge of uart_rx_valid
//   uart_rx_valid      receive strobe (level; only its rising edge counts)
//   uart_tx_ready      transmitter idle (1) / busy (0)
//   uart_transmit_data registered byte presented to the transmitter
//   uart_tx_start      transmit request
//   result             last product, held until the next one
//   result_valid       one-cycle pulse when result updates
//   busy               high in MULT and all TX states
//   rx_timeout         one-cycle pulse when a pending operand A is discarded
//   rx_overrun         one-cycle pulse when a byte is dropped because the block is busy

module uart_mult_ctrl #(
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic        clk_int,
  input  logic        uart_reset,
  input  logic [7:0]  uart_received_data,
  input  logic        uart_rx_valid,
  input  logic        uart_tx_ready,
  output logic [7:0]  uart_transmit_data,
  output logic        uart_tx_start,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        rx_timeout,
  output logic        rx_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_B,
    ST_MULT,
    ST_TX_HI_REQ,
    ST_TX_HI_WAIT,
    ST_TX_LO_REQ,
    ST_TX_LO_WAIT
  } state_t;

  // Shift-add datapath: multiplicand shifts left, multiplier shifts right,
  // the accumulator picks up the multiplicand whenever the multiplier LSB is set.
  typedef struct packed {
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc;
    logic [2:0]  iter;
  } mult_t;

  // Counter compare value; the legal RX_TIMEOUT range fits in 24 bits.
  localparam logic [23:0] TO_LAST = 24'(RX_TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  mult_t       mult;
  logic [7:0]  opa;
  logic [23:0] to_cnt;

  logic        rx_vld_q;
  logic        rx_ev;
  logic        to_hit;
  logic        in_busy;
  logic        mult_last;
  logic [15:0] acc_nxt;

  // Next values of the registered outputs.
  logic [7:0]  tx_dat_nxt;
  logic        tx_start_nxt;
  logic [15:0] result_nxt;
  logic        result_valid_nxt;
  logic        busy_nxt;
  logic        rx_overrun_nxt;

  // ------------------------------------------------------------------
  // Receive strobe edge detect: a level held high yields a single event.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      rx_vld_q <= 1'b0;
    end else begin
      rx_vld_q <= uart_rx_valid;
    end
  end

  assign rx_ev     = uart_rx_valid & ~rx_vld_q;
  assign in_busy   = (state != ST_IDLE) && (state != ST_WAIT_B);
  assign to_hit    = (to_cnt == TO_LAST);
  assign mult_last = (state == ST_MULT) && (mult.iter == 3'd7);
  assign acc_nxt   = mult.acc + (mult.mplier[0] ? mult.mcand : 16'h0000);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (rx_ev) state_nxt = ST_WAIT_B;
      // A byte arriving on the timeout cycle takes priority over the timeout.
      ST_WAIT_B: begin
        if (rx_ev) begin
          state_nxt = ST_MULT;
        end else if (to_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MULT:       if (mult.iter == 3'd7) state_nxt = ST_TX_HI_REQ;
      ST_TX_HI_REQ:  if (!uart_tx_ready) state_nxt = ST_TX_HI_WAIT;
      ST_TX_HI_WAIT: if (uart_tx_ready) state_nxt = ST_TX_LO_REQ;
      ST_TX_LO_REQ:  if (!uart_tx_ready) state_nxt = ST_TX_LO_WAIT;
      ST_TX_LO_WAIT: if (uart_tx_ready) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output logic. Most outputs are registered from the next state so
  // they line up with the state they describe; rx_timeout is decoded directly
  // so it appears on the cycle the counter reaches its limit.
  // ------------------------------------------------------------------
  always_comb begin
    rx_timeout       = 1'b0;
    tx_dat_nxt       = uart_transmit_data;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    tx_start_nxt     = (state_nxt == ST_TX_HI_REQ) || (state_nxt == ST_TX_LO_REQ);
    busy_nxt         = (state_nxt != ST_IDLE) && (state_nxt != ST_WAIT_B);
    rx_overrun_nxt   = rx_ev && in_busy;

    if ((state == ST_WAIT_B) && !rx_ev && to_hit) begin
      rx_timeout = 1'b1;
    end

    // Final iteration: product goes straight to result and the high byte.
    if (mult_last) begin
      result_nxt       = acc_nxt;
      result_valid_nxt = 1'b1;
      tx_dat_nxt       = acc_nxt[15:8];
    end

    if ((state == ST_TX_HI_WAIT) && uart_tx_ready) begin
      tx_dat_nxt = result[7:0];
    end
  end

  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      uart_transmit_data <= 8'h00;
      uart_tx_start      <= 1'b0;
      result             <= 16'h0000;
      result_valid       <= 1'b0;
      busy               <= 1'b0;
      rx_overrun         <= 1'b0;
    end else begin
      uart_transmit_data <= tx_dat_nxt;
      uart_tx_start      <= tx_start_nxt;
      result             <= result_nxt;
      result_valid       <= result_valid_nxt;
      busy               <= busy_nxt;
      rx_overrun         <= rx_overrun_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Operand capture, timeout counter and multiplier datapath.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      opa    <= 8'h00;
      to_cnt <= 24'd0;
      mult   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_ev) begin
            opa    <= uart_received_data;
            to_cnt <= 24'd0;
          end
        end
        ST_WAIT_B: begin
          if (rx_ev) begin
            mult <= '{mcand:  {8'h00, opa},
                      mplier: uart_received_data,
                      acc:    16'h0000,
                      iter:   3'd0};
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        ST_MULT: begin
          mult <= '{mcand:  {mult.mcand[14:0], 1'b0},
                    mplier: {1'b0, mult.mplier[7:1]},
                    acc:    acc_nxt,
                    iter:   mult.iter + 3'd1};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mult_ctrl.sv
// tb_uart_mult_ctrl: self-checking bench for uart_mult_ctrl with a behavioural transmitter.
// Expected products and bytes are queued when operands are driven and compared
// against what the monitor and transmitter model collect.

module tb_uart_mult_ctrl;

  localparam int unsigned RX_TO = 50;

  logic        clk_int = 1'b0;
  logic        uart_reset = 1'b0;
  logic [7:0]  uart_received_data = 8'h00;
  logic        uart_rx_valid = 1'b0;
  logic        uart_tx_ready = 1'b1;
  logic [7:0]  uart_transmit_data;
  logic        uart_tx_start;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        rx_timeout;
  logic        rx_overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int rv_cnt   = 0;
  int to_seen  = 0;
  int ov_seen  = 0;

  logic tx_hold     = 1'b0;
  int   tx_busy_len = 4;
  int   tx_cnt      = 0;

  logic [15:0] exp_res[$];
  logic [15:0] act_res[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  act_bytes[$];

  uart_mult_ctrl #(.RX_TIMEOUT(RX_TO)) dut (
    .clk_int            (clk_int),
    .uart_reset         (uart_reset),
    .uart_received_data (uart_received_data),
    .uart_rx_valid      (uart_rx_valid),
    .uart_tx_ready      (uart_tx_ready),
    .uart_transmit_data (uart_transmit_data),
    .uart_tx_start      (uart_tx_start),
    .result             (result),
    .result_valid       (result_valid),
    .busy               (busy),
    .rx_timeout         (rx_timeout),
    .rx_overrun         (rx_overrun)
  );

  always #5 clk_int = ~clk_int;

  // Transmitter model: latches the byte when start is seen while idle, then stays
  // busy for tx_busy_len cycles. tx_hold freezes it idle without accepting.
  always @(posedge clk_int) begin
    #1;
    if (!uart_reset) begin
      uart_tx_ready = 1'b1;
      tx_cnt = 0;
    end else if (!tx_hold) begin
      if (uart_tx_ready && uart_tx_start) begin
        act_bytes.push_back(uart_transmit_data);
        uart_tx_ready = 1'b0;
        tx_cnt = tx_busy_len;
      end else if (!uart_tx_ready) begin
        tx_cnt--;
        if (tx_cnt <= 0) uart_tx_ready = 1'b1;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk_int) begin
    if (uart_reset) begin
      if (result_valid) begin
        act_res.push_back(result);
        rv_cnt++;
      end
      if (rx_timeout) to_seen++;
      if (rx_overrun) ov_seen++;
    end
  end

  function automatic logic [15:0] pop_act_res();
    if (act_res.size() > 0) return act_res.pop_front();
    return 16'hxxxx;
  endfunction

  function automatic logic [15:0] pop_exp_res();
    if (exp_res.size() > 0) return exp_res.pop_front();
    return 16'hxxxx;
  endfunction

  function automatic logic [7:0] pop_act_byte();
    if (act_bytes.size() > 0) return act_bytes.pop_front();
    return 8'hxx;
  endfunction

  function automatic logic [7:0] pop_exp_byte();
    if (exp_bytes.size() > 0) return exp_bytes.pop_front();
    return 8'hxx;
  endfunction

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  // Drives one receive strobe; returns 1ns after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    tick();
    uart_received_data = b;
    uart_rx_valid = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      tick();
      k++;
    end
    n_checks++;
    if (busy) $display("FAIL %s_idle busy still %b after %0d cycles, required 0", name, busy, k);
    else n_pass++;
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input string name);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    exp_res.push_back(p);
    exp_bytes.push_back(p[15:8]);
    exp_bytes.push_back(p[7:0]);
    send_byte(a);
    send_byte(b);
    wait_idle(name);
  endtask

  task automatic test_reset();
    uart_reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({uart_transmit_data, uart_tx_start, result, result_valid, busy, rx_timeout, rx_overrun} !== 29'd0)
      $display("FAIL reset_outputs got data=%h start=%b result=%h rv=%b busy=%b to=%b ov=%b, required all 0",
               uart_transmit_data, uart_tx_start, result, result_valid, busy, rx_timeout, rx_overrun);
    else n_pass++;
    uart_reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({uart_tx_start, busy, result_valid} !== 3'b000)
      $display("FAIL reset_idle got start=%b busy=%b rv=%b, required 000", uart_tx_start, busy, result_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    int k, rv0, ov0, to0;
    logic [15:0] g16, e16;
    logic [7:0] g8, e8;
    rv0 = rv_cnt; ov0 = ov_seen; to0 = to_seen;
    exp_res.push_back(16'h0014);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h14);
    send_byte(8'h02);
    send_byte(8'h0A);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy_rise got %b required 1", busy);
    else n_pass++;
    // k counts clock edges after the B capture edge.
    k = 0;
    while (result_valid !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    n_checks++;
    if (k != 8) $display("FAIL basic_latency result_valid after %0d edges, required 8", k);
    else n_pass++;
    n_checks++;
    if (uart_tx_start !== 1'b1) $display("FAIL basic_start_with_result got %b required 1", uart_tx_start);
    else n_pass++;
    wait_idle("basic");
    g16 = pop_act_res(); e16 = pop_exp_res();
    n_checks++;
    if (g16 !== e16) $display("FAIL basic_result got %h required %h", g16, e16); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL basic_byte_hi got %h required %h", g8, e8); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL basic_byte_lo got %h required %h", g8, e8); else n_pass++;
    n_checks++;
    if (rv_cnt - rv0 != 1) $display("FAIL basic_rv_pulses got %0d required 1", rv_cnt - rv0); else n_pass++;
    n_checks++;
    if ((ov_seen - ov0) + (to_seen - to0) != 0)
      $display("FAIL basic_no_ov_to got ov=%0d to=%0d required 0 0", ov_seen - ov0, to_seen - to0);
    else n_pass++;
  endtask

  task automatic test_products();
    logic [7:0] a_tab [2];
    logic [7:0] b_tab [2];
    logic [15:0] g16, e16;
    logic [7:0] g8, e8;
    a_tab[0] = 8'hFF; b_tab[0] = 8'hFF;
    a_tab[1] = 8'h00; b_tab[1] = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      run_pair(a_tab[i], b_tab[i], "products");
      g16 = pop_act_res(); e16 = pop_exp_res();
      n_checks++;
      if (g16 !== e16) $display("FAIL products_result[%0d] got %h required %h", i, g16, e16); else n_pass++;
      g8 = pop_act_byte(); e8 = pop_exp_byte();
      n_checks++;
      if (g8 !== e8) $display("FAIL products_hi[%0d] got %h required %h", i, g8, e8); else n_pass++;
      g8 = pop_act_byte(); e8 = pop_exp_byte();
      n_checks++;
      if (g8 !== e8) $display("FAIL products_lo[%0d] got %h required %h", i, g8, e8); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int k, to0;
    logic [15:0] g16, e16;
    logic [7:0] g8, e8;
    to0 = to_seen;
    send_byte(8'h07);
    // Cycle 1 is the first cycle after the A capture edge.
    k = 0;
    while (rx_timeout !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (k + 1 != RX_TO) $display("FAIL timeout_cycle pulse at cycle %0d, required %0d", k + 1, RX_TO);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (to_seen - to0 != 1) $display("FAIL timeout_pulses got %0d required 1", to_seen - to0); else n_pass++;
    run_pair(8'h03, 8'h04, "timeout");
    g16 = pop_act_res(); e16 = pop_exp_res();
    n_checks++;
    if (g16 !== e16) $display("FAIL timeout_result got %h required %h", g16, e16); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL timeout_hi got %h required %h", g8, e8); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL timeout_lo got %h required %h", g8, e8); else n_pass++;
  endtask

  task automatic test_overrun();
    int ov0, rv0;
    logic [15:0] g16, e16;
    logic [7:0] g8, e8;
    ov0 = ov_seen; rv0 = rv_cnt;
    exp_res.push_back(16'h0100);
    exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h00);
    send_byte(8'h10);
    send_byte(8'h10);
    send_byte(8'h55);
    wait_idle("overrun");
    n_checks++;
    if (ov_seen - ov0 != 1) $display("FAIL overrun_pulses got %0d required 1", ov_seen - ov0); else n_pass++;
    n_checks++;
    if (rv_cnt - rv0 != 1) $display("FAIL overrun_rv_pulses got %0d required 1", rv_cnt - rv0); else n_pass++;
    g16 = pop_act_res(); e16 = pop_exp_res();
    n_checks++;
    if (g16 !== e16) $display("FAIL overrun_result got %h required %h", g16, e16); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL overrun_hi got %h required %h", g8, e8); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL overrun_lo got %h required %h", g8, e8); else n_pass++;
    // A stale operand A would turn 0x02 into operand B here.
    run_pair(8'h02, 8'h03, "after_overrun");
    g16 = pop_act_res(); e16 = pop_exp_res();
    n_checks++;
    if (g16 !== e16) $display("FAIL after_overrun_result got %h required %h", g16, e16); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL after_overrun_hi got %h required %h", g8, e8); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL after_overrun_lo got %h required %h", g8, e8); else n_pass++;
  endtask

  task automatic test_hold();
    int rv0;
    logic [15:0] g16, e16;
    logic [7:0] g8, e8;
    rv0 = rv_cnt;
    exp_res.push_back(16'h000F);
    exp_bytes.push_back(8'h00);
    exp_bytes.push_back(8'h0F);
    tick();
    uart_received_data = 8'h03;
    uart_rx_valid = 1'b1;
    repeat (5) tick();
    uart_rx_valid = 1'b0;
    send_byte(8'h05);
    wait_idle("hold");
    repeat (3) tick();
    n_checks++;
    if (rv_cnt - rv0 != 1) $display("FAIL hold_products got %0d required 1", rv_cnt - rv0); else n_pass++;
    g16 = pop_act_res(); e16 = pop_exp_res();
    n_checks++;
    if (g16 !== e16) $display("FAIL hold_result got %h required %h", g16, e16); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL hold_hi got %h required %h", g8, e8); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL hold_lo got %h required %h", g8, e8); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    logic [15:0] g16, e16;
    logic [7:0] g8, e8;
    tx_hold = 1'b1;
    send_byte(8'h09);
    send_byte(8'h07);
    k = 0;
    while (uart_tx_start !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    n_checks++;
    if (uart_tx_start !== 1'b1) $display("FAIL rstmid_reach_req start got %b required 1", uart_tx_start);
    else n_pass++;
    #2;
    uart_reset = 1'b0;
    #1;
    n_checks++;
    if (uart_tx_start !== 1'b0) $display("FAIL rstmid_start got %b required 0", uart_tx_start); else n_pass++;
    n_checks++;
    if ({uart_transmit_data, result, result_valid, busy, rx_timeout, rx_overrun} !== 28'd0)
      $display("FAIL rstmid_outputs got data=%h result=%h rv=%b busy=%b to=%b ov=%b, required all 0",
               uart_transmit_data, result, result_valid, busy, rx_timeout, rx_overrun);
    else n_pass++;
    tick();
    uart_reset = 1'b1;
    tx_hold = 1'b0;
    act_res.delete();
    act_bytes.delete();
    tick();
    run_pair(8'h02, 8'h03, "rstmid");
    g16 = pop_act_res(); e16 = pop_exp_res();
    n_checks++;
    if (g16 !== e16) $display("FAIL rstmid_result got %h required %h", g16, e16); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL rstmid_hi got %h required %h", g8, e8); else n_pass++;
    g8 = pop_act_byte(); e8 = pop_exp_byte();
    n_checks++;
    if (g8 !== e8) $display("FAIL rstmid_lo got %h required %h", g8, e8); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [15:0] g16, e16;
    logic [7:0] g8, e8;
    for (int i = 0; i < 4; i++) begin
      tx_busy_len = (i % 2 == 0) ? 1 : int'($urandom_range(2, 7));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_pair(a, b, "b2b");
      g16 = pop_act_res(); e16 = pop_exp_res();
      n_checks++;
      if (g16 !== e16) $display("FAIL b2b_result[%0d] %h*%h got %h required %h", i, a, b, g16, e16); else n_pass++;
      g8 = pop_act_byte(); e8 = pop_exp_byte();
      n_checks++;
      if (g8 !== e8) $display("FAIL b2b_hi[%0d] got %h required %h", i, g8, e8); else n_pass++;
      g8 = pop_act_byte(); e8 = pop_exp_byte();
      n_checks++;
      if (g8 !== e8) $display("FAIL b2b_lo[%0d] got %h required %h", i, g8, e8); else n_pass++;
    end
    tx_busy_len = 4;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_products();
    test_timeout();
    test_overrun();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
